// File: rtl/hub75_pkg.sv
// hub75_pkg: shared scan states, rd_data field layout and cycle-count helpers
package hub75_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, SHOW} state_t;

    localparam int CH_R0 = 0;
    localparam int CH_G0 = 1;
    localparam int CH_B0 = 2;
    localparam int CH_R1 = 3;
    localparam int CH_G1 = 4;
    localparam int CH_B1 = 5;

    function automatic int ch_bit(input int ch, input int p, input int bpc);
        return ch * bpc + p;
    endfunction

    function automatic int plane_cycles(input int cols, input int base_on, input int p);
        return 2 * cols + 3 + (base_on << p);
    endfunction

    function automatic int row_cycles(input int cols, input int bpc, input int base_on);
        return bpc * (2 * cols + 3) + base_on * ((1 << bpc) - 1);
    endfunction

    function automatic int frame_cycles(input int cols, input int row_aw, input int bpc, input int base_on);
        return (1 << row_aw) * row_cycles(cols, bpc, base_on);
    endfunction

endpackage

// File: rtl/hub75_col_shifter.sv
// hub75_col_shifter: column fetch and shift-clock serialiser for one bit plane of one row
module hub75_col_shifter
    import hub75_pkg::*;
#(
    parameter int COLS   = 64,
    parameter int ROW_AW = 4,
    parameter int BPC    = 4
)(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [$clog2(BPC > 1 ? BPC : 2)-1:0] plane,
    input  logic [ROW_AW-1:0]                  row,
    output logic                               rd_en,
    output logic [ROW_AW-1:0]                  rd_row,
    output logic [$clog2(COLS)-1:0]            rd_col,
    input  logic [6*BPC-1:0]                   rd_data,
    output logic                               sclk,
    output logic [2:0]                         rgb0,
    output logic [2:0]                         rgb1,
    output logic                               done
);

    localparam int CW = $clog2(COLS);
    localparam int TW = $clog2(2 * COLS + 2);

    logic [TW-1:0]          t;
    logic                   last;
    logic [5:0][BPC-1:0]    ch;

    assign ch     = rd_data;
    assign last   = t == TW'(2 * COLS + 1);
    assign done   = start && last;
    assign rd_en  = start && !t[0] && t < TW'(2 * COLS);
    assign rd_row = row;
    assign rd_col = t[CW:1];

    // step counter for the shift phase, rewinds at the last step of every plane
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) t <= '0;
        else if (start) t <= last ? '0 : t + 1'b1;

    // odd steps load the fetched bit with sclk low, even steps raise sclk on stable data
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk <= 1'b0;
            rgb0 <= '0;
            rgb1 <= '0;
        end else if (start) begin
            sclk <= !t[0] && t != '0;
            if (t[0] && t < TW'(2 * COLS)) begin
                rgb0 <= {ch[CH_B0][plane], ch[CH_G0][plane], ch[CH_R0][plane]};
                rgb1 <= {ch[CH_B1][plane], ch[CH_G1][plane], ch[CH_R1][plane]};
            end
        end

endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 row scanner with binary-coded modulation over BPC bit planes
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int COLS    = 64,
    parameter int ROW_AW  = 4,
    parameter int BPC     = 4,
    parameter int BASE_ON = 8
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic                    rd_en,
    output logic [ROW_AW-1:0]       rd_row,
    output logic [$clog2(COLS)-1:0] rd_col,
    input  logic [6*BPC-1:0]        rd_data,
    output logic                    sclk,
    output logic [2:0]              rgb0,
    output logic [2:0]              rgb1,
    output logic [ROW_AW-1:0]       addr,
    output logic                    lat,
    output logic                    oe,
    output logic                    frame_done
);

    localparam int PW = $clog2(BPC > 1 ? BPC : 2);
    localparam int SW = $clog2(BASE_ON << (BPC - 1)) + 1;

    state_t          state;
    logic [PW-1:0]   p;
    logic [ROW_AW-1:0] r;
    logic [SW-1:0]   cnt;
    logic            shift_done;
    logic            last_plane;

    assign last_plane = p == PW'(BPC - 1);

    hub75_col_shifter #(.COLS(COLS), .ROW_AW(ROW_AW), .BPC(BPC)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state == SHIFT),
        .plane   (p),
        .row     (r),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data),
        .sclk    (sclk),
        .rgb0    (rgb0),
        .rgb1    (rgb1),
        .done    (shift_done)
    );

    // scan sequencer: shift a plane, latch it, then light it for its binary weight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            p          <= '0;
            r          <= '0;
            cnt        <= '0;
            addr       <= '0;
            lat        <= 1'b0;
            oe         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (enable) state <= SHIFT;
                SHIFT: if (shift_done) begin
                    state <= LATCH;
                    lat   <= 1'b1;
                    if (p == '0) addr <= r;
                end
                LATCH: begin
                    state <= SHOW;
                    lat   <= 1'b0;
                    oe    <= 1'b0;
                    cnt   <= (SW'(BASE_ON) << p) - SW'(1);
                end
                SHOW: if (cnt == '0) begin
                    oe    <= 1'b1;
                    state <= enable ? SHIFT : IDLE;
                    if (last_plane) begin
                        p          <= '0;
                        r          <= r + 1'b1;
                        frame_done <= &r;
                    end else p <= p + 1'b1;
                end else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: scoreboard bench for the HUB75 BCM scan driver
module tb_hub75_bcm_driver;
    import hub75_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // small configuration: COLS=4 ROW_AW=2 BPC=2 BASE_ON=2
    logic        rst_n = 1'b0, enable = 1'b0;
    logic        rd_en, sclk, lat, oe, frame_done;
    logic [1:0]  rd_row, rd_col, addr;
    logic [11:0] rd_data = '0;
    logic [2:0]  rgb0, rgb1;

    hub75_bcm_driver #(.COLS(4), .ROW_AW(2), .BPC(2), .BASE_ON(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rd_en(rd_en), .rd_row(rd_row),
        .rd_col(rd_col), .rd_data(rd_data), .sclk(sclk), .rgb0(rgb0), .rgb1(rgb1),
        .addr(addr), .lat(lat), .oe(oe), .frame_done(frame_done)
    );

    // frame buffer: 1-cycle read latency, poisoned data when not read
    int mode = 0;
    always @(posedge clk) begin
        logic [11:0] d;
        d = (mode == 0) ? 12'hFFF : (12'(rd_col) << ch_bit(CH_R0, 0, 2));
        rd_data <= rd_en ? d : ~d;
    end

    // full-size configuration for continuous invariants
    logic        rst_big = 1'b0;
    logic        rd_en_b, sclk_b, lat_b, oe_b, fd_b;
    logic [3:0]  rd_row_b, addr_b;
    logic [5:0]  rd_col_b;
    logic [23:0] rd_data_b = '0;
    logic [2:0]  rgb0_b, rgb1_b;

    hub75_bcm_driver #(.COLS(64), .ROW_AW(4), .BPC(4), .BASE_ON(8)) dut_big (
        .clk(clk), .rst_n(rst_big), .enable(1'b1), .rd_en(rd_en_b), .rd_row(rd_row_b),
        .rd_col(rd_col_b), .rd_data(rd_data_b), .sclk(sclk_b), .rgb0(rgb0_b), .rgb1(rgb1_b),
        .addr(addr_b), .lat(lat_b), .oe(oe_b), .frame_done(fd_b)
    );

    always @(posedge clk) rd_data_b <= {2{rd_row_b, rd_col_b, 2'b01}};

    // scoreboard queues
    logic [5:0] exp_rgb[$];
    int exp_show[$];
    int exp_addr[$];
    int exp_gap[$];

    int   show_len = 0, lat_cnt = 0, fd_cnt = 0, cyc = 0, last_fd = 0;
    bit   fd_seen = 0;
    logic prev_sclk = 1'b0, prev_oe = 1'b1;
    logic [5:0] prev_rgb = '0;

    // monitor for the small DUT
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            show_len = 0;
            fd_seen = 0;
            prev_sclk = 1'b0;
            prev_oe = 1'b1;
            prev_rgb = '0;
        end else begin
            chk("lat_oe_overlap", 32'(lat & ~oe), 0);
            if (sclk && !prev_sclk) begin
                chk("rgb_stable_on_sclk_rise", 32'({rgb1, rgb0}), 32'(prev_rgb));
                if (exp_rgb.size() > 0) chk("rgb_on_sclk_rise", 32'({rgb1, rgb0}), 32'(exp_rgb.pop_front()));
            end
            if (!oe) show_len++;
            else if (!prev_oe) begin
                if (exp_show.size() > 0) chk("show_len", show_len, exp_show.pop_front());
                show_len = 0;
            end
            if (lat) begin
                lat_cnt++;
                if (exp_addr.size() > 0) chk("addr_at_latch", 32'(addr), exp_addr.pop_front());
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_seen && exp_gap.size() > 0) chk("frame_gap", cyc - last_fd, exp_gap.pop_front());
                last_fd = cyc;
                fd_seen = 1;
            end
            prev_sclk = sclk;
            prev_oe = oe;
            prev_rgb = {rgb1, rgb0};
        end
    end

    int   rises_b = 0, fdb_cnt = 0, cyc_b = 0, last_fd_b = 0;
    logic prev_sclk_b = 1'b0;

    // monitor for the full-size DUT
    always @(negedge clk) begin
        cyc_b++;
        if (rst_big) begin
            chk("big_lat_oe_overlap", 32'(lat_b & ~oe_b), 0);
            if (sclk_b && !prev_sclk_b) rises_b++;
            prev_sclk_b = sclk_b;
            if (lat_b) begin
                chk("big_sclk_rises_per_latch", rises_b, 64);
                rises_b = 0;
            end
            if (fd_b) begin
                if (fdb_cnt > 0) chk("big_frame_len", cyc_b - last_fd_b, 10304);
                last_fd_b = cyc_b;
                fdb_cnt++;
            end
        end
    end

    task automatic wait_lat(input int n);
        for (int k = 0; k < 500 && lat_cnt < n; k++) @(negedge clk);
        chk("wait_latch", 32'(lat_cnt >= n), 1);
    endtask

    task automatic wait_oe(input logic v);
        for (int k = 0; k < 500 && oe !== v; k++) @(negedge clk);
        chk("wait_oe", 32'(oe), 32'(v));
    endtask

    task automatic push_rgb(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
        exp_rgb.push_back(a);
        exp_rgb.push_back(b);
        exp_rgb.push_back(c);
        exp_rgb.push_back(d);
    endtask

    task automatic check_first_read(input int row);
        @(posedge clk);
        #1;
        chk("first_rd_en", 32'(rd_en), 1);
        chk("first_rd_row", 32'(rd_row), row);
        chk("first_rd_col", 32'(rd_col), 0);
    endtask

    initial begin
        int base;
        int bad;
        #12 rst_big = 1'b1;
    end

    initial begin
        int base;
        int bad;
        repeat (3) @(negedge clk);
        chk("reset_oe", 32'(oe), 1);
        chk("reset_lat", 32'(lat), 0);
        chk("reset_sclk", 32'(sclk), 0);
        chk("reset_addr", 32'(addr), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        chk("reset_rd_en", 32'(rd_en), 0);

        // all-ones data, enable held: two full frames
        for (int i = 0; i < 8; i++) begin
            exp_show.push_back(2);
            exp_show.push_back(4);
            exp_addr.push_back(i % 4);
            exp_addr.push_back(i % 4);
        end
        for (int i = 0; i < 64; i++) exp_rgb.push_back(6'h3F);
        exp_gap.push_back(112);
        mode = 0;
        enable = 1'b1;
        rst_n = 1'b1;
        chk("idle_rd_en", 32'(rd_en), 0);
        check_first_read(0);
        for (int k = 0; k < 400 && fd_cnt < 2; k++) @(negedge clk);
        chk("wait_two_frames", 32'(fd_cnt >= 2), 1);

        // column pattern R0=c, then drop enable in row 2 plane 0
        rst_n = 1'b0;
        @(negedge clk);
        mode = 1;
        @(negedge clk);
        base = lat_cnt;
        push_rgb(6'd0, 6'd1, 6'd0, 6'd1);
        push_rgb(6'd0, 6'd0, 6'd1, 6'd1);
        exp_addr.push_back(0);
        exp_addr.push_back(0);
        exp_show.push_back(2);
        exp_show.push_back(4);
        rst_n = 1'b1;
        wait_lat(base + 4);
        wait_oe(1'b0);
        wait_oe(1'b1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        exp_show.push_back(2);
        exp_addr.push_back(2);
        wait_lat(base + 5);
        wait_oe(1'b0);
        wait_oe(1'b1);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd_en || sclk || !oe || lat) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_no_extra_latch", lat_cnt, base + 5);
        chk("idle_addr_kept", 32'(addr), 2);

        // resume: plane 1 of row 2
        push_rgb(6'd0, 6'd0, 6'd1, 6'd1);
        exp_show.push_back(4);
        exp_addr.push_back(2);
        enable = 1'b1;
        check_first_read(2);
        wait_lat(base + 6);
        wait_oe(1'b0);
        wait_oe(1'b1);

        // reset while lit
        wait_oe(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_oe", 32'(oe), 1);
        chk("async_reset_lat", 32'(lat), 0);
        chk("async_reset_addr", 32'(addr), 0);
        repeat (2) @(negedge clk);
        base = lat_cnt;
        push_rgb(6'd0, 6'd1, 6'd0, 6'd1);
        exp_addr.push_back(0);
        exp_show.push_back(2);
        rst_n = 1'b1;
        check_first_read(0);
        wait_lat(base + 1);
        wait_oe(1'b0);
        wait_oe(1'b1);

        // let the full-size instance complete two frames
        for (int k = 0; k < 30000 && fdb_cnt < 2; k++) @(negedge clk);
        chk("big_two_frames", 32'(fdb_cnt >= 2), 1);

        chk("rgb_queue_drained", exp_rgb.size(), 0);
        chk("show_queue_drained", exp_show.size(), 0);
        chk("addr_queue_drained", exp_addr.size(), 0);
        chk("gap_queue_drained", exp_gap.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
